trdb_word_buffer: RTL and testbench

Elastic buffer directly downstream of the packet-to-word aligner stage. It captures the 32-bit trace words the aligner emits and holds them for a ready/valid consumer such as a bus slave or DMA readout. The aligner output has no backpressure, so on overflow the buffer drops words, counts them and raises a sticky flag for software.

---
 rtl/trdb_pkg.sv | 9 +
 rtl/trdb_word_buffer.sv | 124 ++++++++++++
 tb/tb_trdb_word_buffer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/trdb_pkg.sv
// trdb_pkg
// Shared widths for the trace debug datapath (aligner, word buffer, readout).
// No ports; imported by the trace blocks.
package trdb_pkg;

    localparam int unsigned TRDB_WORD_LEN     = 32;
    localparam int unsigned TRDB_DROP_CNT_LEN = 16;

endpackage : trdb_pkg

// File: rtl/trdb_word_buffer.sv
// trdb_word_buffer
// Elastic FIFO between the packet-to-word aligner and a ready/valid consumer.
// The aligner cannot be stalled, so a word arriving while the buffer is full
// and nothing is being popped is dropped, counted and flagged.
//
// Ports:
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   flush_i         synchronous discard of all stored words
//   data_i/valid_i  word strobe from the aligner (no backpressure)
//   data_o/valid_o  head word, first-word-fall-through, qualified by valid_o
//   ready_i         consumer accepts data_o this cycle
//   level_o         number of stored words
//   watermark_o     level_o >= WATERMARK
//   overflow_o      sticky drop flag
//   drop_count_o    saturating dropped-word count
//   overflow_clr_i  clears overflow_o and drop_count_o
module trdb_word_buffer
    import trdb_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WATERMARK = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [TRDB_WORD_LEN-1:0]     data_i,
    input  logic                         valid_i,
    output logic [TRDB_WORD_LEN-1:0]     data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(DEPTH):0]       level_o,
    output logic                         watermark_o,
    output logic                         overflow_o,
    output logic [TRDB_DROP_CNT_LEN-1:0] drop_count_o,
    input  logic                         overflow_clr_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [TRDB_WORD_LEN-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]             r_wr_ptr;
    logic [PTR_W-1:0]             r_rd_ptr;
    logic [LVL_W-1:0]             r_level;
    logic                         r_overflow;
    logic [TRDB_DROP_CNT_LEN-1:0] r_drop_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = ~w_empty & ready_i;
    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign w_push  = valid_i & (~w_full | w_pop);
    // Words discarded by a flush are not drops.
    assign w_drop  = valid_i & w_full & ~w_pop & ~flush_i;

    // Storage is reset so data_o reads zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !flush_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    // A drop coinciding with a clear wins: the new drop is the first one
    // counted after the clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (overflow_clr_i) begin
                r_drop_count <= TRDB_DROP_CNT_LEN'(1);
            end else if (r_drop_count != '1) begin
                r_drop_count <= r_drop_count + TRDB_DROP_CNT_LEN'(1);
            end
        end else if (overflow_clr_i) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    assign data_o       = r_mem[r_rd_ptr];
    assign valid_o      = ~w_empty;
    assign level_o      = r_level;
    assign watermark_o  = (r_level >= LVL_W'(WATERMARK));
    assign overflow_o   = r_overflow;
    assign drop_count_o = r_drop_count;

endmodule : trdb_word_buffer

// File: tb/tb_trdb_word_buffer.sv
// tb_trdb_word_buffer
// Directed bench for trdb_word_buffer (DEPTH=16, WATERMARK=8).
module tb_trdb_word_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic [4:0]  level_o;
    logic        watermark_o;
    logic        overflow_o;
    logic [15:0] drop_count_o;
    logic        overflow_clr_i;

    int checks = 0;
    int errors = 0;

    trdb_word_buffer #(.DEPTH(16), .WATERMARK(8)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .data_i         (data_i),
        .valid_i        (valid_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .level_o        (level_o),
        .watermark_o    (watermark_o),
        .overflow_o     (overflow_o),
        .drop_count_o   (drop_count_o),
        .overflow_clr_i (overflow_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni         = 1'b0;
        flush_i        = 1'b0;
        data_i         = '0;
        valid_i        = 1'b0;
        ready_i        = 1'b0;
        overflow_clr_i = 1'b0;

        #3;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_level", 32'(level_o), 0);
        chk("rst_wm", 32'(watermark_o), 0);
        chk("rst_ovf", 32'(overflow_o), 0);
        chk("rst_dcnt", 32'(drop_count_o), 0);
        chk("rst_data", data_o, 0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // three words, consumer stalled, then drained in order
        for (int i = 0; i < 3; i++) begin
            data_i  = 32'hA0 + 32'(i);
            valid_i = 1'b1;
            tick();
        end
        valid_i = 1'b0;
        chk("t1_level3", 32'(level_o), 3);
        chk("t1_valid", 32'(valid_o), 1);
        chk("t1_head", data_o, 32'hA0);
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_pop_data", data_o, 32'hA0 + 32'(i));
            chk("t1_pop_valid", 32'(valid_o), 1);
            tick();
        end
        chk("t1_empty_level", 32'(level_o), 0);
        chk("t1_empty_valid", 32'(valid_o), 0);

        // single word into empty buffer with ready held: no bypass
        data_i  = 32'hB0;
        valid_i = 1'b1;
        chk("t2_no_bypass", 32'(valid_o), 0);
        tick();
        valid_i = 1'b0;
        chk("t2_valid_next", 32'(valid_o), 1);
        chk("t2_data", data_o, 32'hB0);
        chk("t2_level1", 32'(level_o), 1);
        tick();
        chk("t2_valid_gone", 32'(valid_o), 0);
        chk("t2_level0", 32'(level_o), 0);
        ready_i = 1'b0;

        // fill to 16, watermark from the 8th word, then one drop
        for (int i = 0; i < 16; i++) begin
            data_i  = 32'h100 + 32'(i);
            valid_i = 1'b1;
            tick();
            chk("t3_level", 32'(level_o), 32'(i + 1));
            chk("t3_wm", 32'(watermark_o), (i + 1 >= 8) ? 1 : 0);
        end
        data_i = 32'hDEAD;
        tick();
        valid_i = 1'b0;
        chk("t3_full_level", 32'(level_o), 16);
        chk("t3_ovf", 32'(overflow_o), 1);
        chk("t3_dcnt", 32'(drop_count_o), 1);

        // full with simultaneous push and pop for 4 cycles
        valid_i = 1'b1;
        ready_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            data_i = 32'h200 + 32'(j);
            chk("t4_head", data_o, 32'h100 + 32'(j));
            tick();
            chk("t4_level", 32'(level_o), 16);
            chk("t4_dcnt", 32'(drop_count_o), 1);
        end
        valid_i = 1'b0;
        for (int j = 0; j < 16; j++) begin
            chk("t4_drain", data_o, (j < 12) ? 32'h104 + 32'(j) : 32'h200 + 32'(j - 12));
            tick();
        end
        chk("t4_drained", 32'(level_o), 0);
        ready_i = 1'b0;

        // saturate the drop counter
        for (int i = 0; i < 16; i++) begin
            data_i  = 32'h400 + 32'(i);
            valid_i = 1'b1;
            tick();
        end
        data_i = 32'hBAD0;
        for (int i = 0; i < 65534; i++) begin
            tick();
        end
        chk("t5_sat", 32'(drop_count_o), 32'hFFFF);
        tick();
        chk("t5_sat_hold", 32'(drop_count_o), 32'hFFFF);
        chk("t5_untouched", data_o, 32'h400);
        chk("t5_level", 32'(level_o), 16);
        overflow_clr_i = 1'b1;
        tick();
        chk("t5_clr_drop_ovf", 32'(overflow_o), 1);
        chk("t5_clr_drop_cnt", 32'(drop_count_o), 1);
        valid_i = 1'b0;
        tick();
        overflow_clr_i = 1'b0;
        chk("t5_clr_ovf", 32'(overflow_o), 0);
        chk("t5_clr_cnt", 32'(drop_count_o), 0);

        // flush: one drop first so the sticky flag is set going in
        data_i  = 32'hCAFE;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        chk("t6_pre_ovf", 32'(overflow_o), 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("t6_flush_level", 32'(level_o), 0);
        chk("t6_flush_dcnt", 32'(drop_count_o), 1);
        for (int i = 0; i < 5; i++) begin
            data_i  = 32'h300 + 32'(i);
            valid_i = 1'b1;
            tick();
        end
        chk("t6_five", 32'(level_o), 5);
        chk("t6_ptr_reset_head", data_o, 32'h300);
        data_i  = 32'h3FF;
        ready_i = 1'b1;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        chk("t6_level0", 32'(level_o), 0);
        chk("t6_valid0", 32'(valid_o), 0);
        chk("t6_ovf_kept", 32'(overflow_o), 1);
        chk("t6_dcnt_kept", 32'(drop_count_o), 1);
        data_i  = 32'h500;
        valid_i = 1'b1;
        tick();
        data_i = 32'h501;
        tick();
        valid_i = 1'b0;
        chk("t6_after_flush_head", data_o, 32'h500);
        chk("t6_after_flush_level", 32'(level_o), 2);

        // asynchronous reset mid-stream
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t7_valid", 32'(valid_o), 0);
        chk("t7_level", 32'(level_o), 0);
        chk("t7_wm", 32'(watermark_o), 0);
        chk("t7_ovf", 32'(overflow_o), 0);
        chk("t7_dcnt", 32'(drop_count_o), 0);
        chk("t7_data", data_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_trdb_word_buffer
